// File: rtl/ped_req_pkg.sv
// Shared types and constants for the pedestrian request front end.
// Optional watchdog is enabled in the top with PED_REQ_TIMEOUT_EN.
package ped_req_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    COOLDOWN = 2'd2
  } ped_req_state_t;

  localparam logic [7:0] PRESS_CNT_MAX = 8'd255;

  // 100 MHz defaults: 10 ms debounce, 3 s cooldown, 20 s pending watchdog
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned COOLDOWN_CYCLES_DEF = 300_000_000;
  localparam int unsigned TIMEOUT_CYCLES_DEF  = 2_000_000_000;
  localparam int unsigned CNT_W_DEF           = 32;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == PRESS_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stable-level debounce; emits a one-cycle
// pulse on each accepted rising edge of the button.
module button_debounce
  import ped_req_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic button_raw,
  output logic press
);

  // Counter saturates at the last differing edge, so it only needs to reach D-1.
  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'((DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic             db_dly_q, db_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = button_raw;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_dly_d = db_q;
    cnt_d    = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/ped_request_gen.sv
// Pedestrian push-button front end: debounced press -> held request until ack,
// then a cooldown. Define PED_REQ_TIMEOUT_EN to add the pending watchdog.
module ped_request_gen
  import ped_req_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       button_raw,
  input  logic       ack,
  output logic       request,
  output logic       cooldown,
  output logic [7:0] press_count,
  output logic       timeout_err
);

  // Cooldown counts down from C-1 so the flag stays high for exactly C cycles.
  localparam logic [CNT_W-1:0] CD_LAST =
    CNT_W'((COOLDOWN_CYCLES == 0) ? 0 : COOLDOWN_CYCLES - 1);

  logic           press;
  ped_req_state_t state_q, state_d;
  logic           request_q, request_d;
  logic           cooldown_q, cooldown_d;
  logic [7:0]     press_count_q, press_count_d;
  logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;

`ifdef PED_REQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .button_raw (button_raw),
    .press      (press)
  );

  always_comb begin
    state_d       = state_q;
    request_d     = request_q;
    cooldown_d    = cooldown_q;
    press_count_d = press_count_q;
    cd_cnt_d      = cd_cnt_q;
`ifdef PED_REQ_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
    to_cnt_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d       = PENDING;
          request_d     = 1'b1;
          press_count_d = sat_inc8(press_count_q);
        end
      end
      PENDING: begin
        // ack wins over a coincident watchdog expiry
        if (ack) begin
          state_d    = COOLDOWN;
          request_d  = 1'b0;
          cooldown_d = 1'b1;
          cd_cnt_d   = CD_LAST;
        end
`ifdef PED_REQ_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          state_d       = IDLE;
          request_d     = 1'b0;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
`endif
      end
      COOLDOWN: begin
        // a press landing on the exit edge is dropped, not latched
        if (cd_cnt_q == '0) begin
          state_d    = IDLE;
          cooldown_d = 1'b0;
        end else begin
          cd_cnt_d = cd_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        request_d  = 1'b0;
        cooldown_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q       <= IDLE;
      request_q     <= 1'b0;
      cooldown_q    <= 1'b0;
      press_count_q <= 8'd0;
      cd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      request_q     <= request_d;
      cooldown_q    <= cooldown_d;
      press_count_q <= press_count_d;
      cd_cnt_q      <= cd_cnt_d;
    end
  end

`ifdef PED_REQ_TIMEOUT_EN
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      timeout_err_q <= timeout_err_d;
      to_cnt_q      <= to_cnt_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign request     = request_q;
  assign cooldown    = cooldown_q;
  assign press_count = press_count_q;

endmodule

// File: doc/ped_request_gen.md
Name: ped_request_gen

Overview:
- Pedestrian push-button front end. It produces the `request` input that the traffic-light controller top consumes.
- Synchronises and debounces the raw button, then raises a level request held until the controller returns `ack`. `ack` marks the pedestrian-green phase being served.
- Enforces a cooldown after each served request so repeated presses cannot starve car traffic.
- Sits between the board button pin and the controller.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz); minimum 1.
- COOLDOWN_CYCLES, 300_000_000, cycles after `ack` during which presses are ignored (3 s); value 0 treated as 1.
- TIMEOUT_CYCLES, 2_000_000_000, cycles a request may stay pending before watchdog abort (optional feature only).
- CNT_W, 32, width of the internal debounce/cooldown/timeout counters; must hold every cycle parameter.

Ports:
- clk_100MHz  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset
- button_raw  input  1  asynchronous raw pedestrian button, active high
- ack  input  1  controller acknowledge; high for ≥1 cycle when pedestrian phase is granted
- request  output  1  level request to controller
- cooldown  output  1  high while in COOLDOWN
- press_count  output  8  accepted presses, saturating at 255
- timeout_err  output  1  sticky watchdog flag (tied 0 when feature compiled out)

Behaviour:
- One clock (clk_100MHz); reset is synchronous and active-high. All state updates on the rising edge.
- Reset values:
  - request=0, cooldown=0, press_count=0, timeout_err=0
  - synchroniser flops=0, debounced level=0, delayed debounced level=0
  - all counters=0, state=IDLE
- Reset mid-operation aborts any pending or cooldown state immediately.
- A button still held after reset is seen as a new press once debounce completes.
- Synchroniser: two flops; output `s`.
- Debounce:
  - Counter increments each edge where `s != db`.
  - Counter clears on any edge where `s == db`.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, `db <= s` and the counter clears.
- Press event: `press = db & ~db_d`, where `db_d` is `db` delayed one cycle. This is a single-cycle pulse.
- FSM states: IDLE, PENDING, COOLDOWN.
  - IDLE → PENDING on `press`; request<=1, press_count increments (saturating). `ack` is ignored in IDLE, including when coincident with `press`.
  - PENDING: request held 1. Further presses are ignored and not counted. On `ack`=1: request<=0, cooldown<=1, cooldown counter loads, state→COOLDOWN.
  - COOLDOWN: presses ignored, `ack` ignored. After COOLDOWN_CYCLES edges: cooldown<=0, state→IDLE.
- A press whose debounced edge lands on the same edge as the COOLDOWN→IDLE transition is dropped; no latching of cooldown presses.
- Latency: count the first edge that samples button_raw=1 as edge 1. Request is high after edge DEBOUNCE_CYCLES+3 when button_raw is stable.
- Request de-asserts on the edge after `ack` is sampled high, i.e. one registered cycle.
- Glitches shorter than DEBOUNCE_CYCLES cycles (post-synchroniser) produce no press.

Optional Feature:
- Macro: PED_REQ_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in PENDING.
  - If TIMEOUT_CYCLES elapse without `ack`: request<=0, timeout_err<=1 (sticky until reset), state→IDLE with no cooldown.
  - `ack` on the same edge as expiry wins: normal COOLDOWN, no error.
- Undefined: no timeout counter; timeout_err tied 0; PENDING waits indefinitely.

Decomposition:
- Package ped_req_pkg:
  - typedef enum logic [1:0] {IDLE, PENDING, COOLDOWN} ped_req_state_t
  - constant PRESS_CNT_MAX=8'd255
  - default cycle constants
- Sub-module button_debounce: synchroniser, debounce counter, `press` pulse output. Parameterised by DEBOUNCE_CYCLES and CNT_W.

Test Plan:
Benches use DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, TIMEOUT_CYCLES=20.
- Reset, then button_raw=1 held → request=1 after edge 7, press_count=1, cooldown=0.
- 3-cycle button pulse, and separately 1-cycle glitch trains → request stays 0, press_count=0.
- Request pending, second press 20 cycles later, ack pulse → request=0 next edge, press_count=1, cooldown=1 for exactly 8 cycles then 0.
- Press during COOLDOWN, and ack while IDLE → no request, press_count unchanged; a press after COOLDOWN ends asserts request normally.
- reset pulse while PENDING and while COOLDOWN → all outputs 0 next edge; 300 valid presses with acks → press_count=255.
- With PED_REQ_TIMEOUT_EN: no ack for 20 cycles in PENDING → request=0, timeout_err=1 (sticky), state IDLE. Ack on the expiry edge → cooldown=1, timeout_err=0.
